// File: rtl/bus_responder.sv
// bus_responder: target side of the 65C02 core bus.
// Decodes the core address into internal RAM, one external I/O page, or
// unmapped space. RAM and unmapped accesses complete with zero wait states.
// I/O accesses stall the core (RDY=0) while a req/ack handshake runs. The
// handshake is bounded by a timeout that returns 8'hFF and sets a sticky error.
module bus_responder #(
    parameter int         RAM_AW  = 12,
    parameter logic [7:0] IO_PAGE = 8'hD0,
    parameter int         TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DB,
    output logic        RDY,
    output logic        ext_req,
    output logic        ext_we,
    output logic [7:0]  ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last timer value before the handshake is abandoned.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_db;
    logic [7:0]  w_db_next;
    logic        w_db_from_ram;
    logic        r_ext_req;
    logic        w_ext_req_next;
    logic        r_ext_we;
    logic        w_ext_we_next;
    logic [7:0]  r_ext_addr;
    logic [7:0]  w_ext_addr_next;
    logic [7:0]  r_ext_wdata;
    logic [7:0]  w_ext_wdata_next;
    logic [7:0]  r_timer;
    logic [7:0]  w_timer_next;
    logic        r_err;
    logic        w_err_next;
    logic        w_ram_we;

    // RAM storage; contents survive reset.
    logic [7:0]  r_ram [0:(2**RAM_AW)-1];

    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_hit_ram;
    logic              w_hit_io;

    assign w_ram_addr = AB[RAM_AW-1:0];
    assign w_hit_ram  = ((AB >> RAM_AW) == 16'd0);
    assign w_hit_io   = (AB[15:8] == IO_PAGE);

    // Next-state and next-register values; RAM has priority in the decode.
    always_comb begin
        w_state_next     = r_state;
        w_db_next        = r_db;
        w_db_from_ram    = 1'b0;
        w_ram_we         = 1'b0;
        w_ext_req_next   = r_ext_req;
        w_ext_we_next    = r_ext_we;
        w_ext_addr_next  = r_ext_addr;
        w_ext_wdata_next = r_ext_wdata;
        w_timer_next     = r_timer;
        w_err_next       = r_err;
        case (r_state)
            S_REQ: begin
                w_timer_next = r_timer + 8'd1;
                if (ext_ack) begin
                    // Ack wins over a simultaneous timeout.
                    w_state_next   = S_DONE;
                    w_ext_req_next = 1'b0;
                    if (!r_ext_we) begin
                        w_db_next = ext_rdata;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_state_next   = S_DONE;
                    w_ext_req_next = 1'b0;
                    w_db_next      = 8'hFF;
                    w_err_next     = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new access (RDY=1).
                w_state_next = S_IDLE;
                if (w_hit_ram) begin
                    w_ram_we      = WE;
                    w_db_from_ram = ~WE;
                end else if (w_hit_io) begin
                    w_state_next     = S_REQ;
                    w_ext_req_next   = 1'b1;
                    w_ext_we_next    = WE;
                    w_ext_addr_next  = AB[7:0];
                    w_ext_wdata_next = DO;
                    w_timer_next     = 8'd0;
                end else if (!WE) begin
                    w_db_next = 8'hFF;
                end
            end
        endcase
    end

    // State and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= 8'd0;
            r_ext_wdata <= 8'd0;
            r_timer     <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ext_req   <= w_ext_req_next;
            r_ext_we    <= w_ext_we_next;
            r_ext_addr  <= w_ext_addr_next;
            r_ext_wdata <= w_ext_wdata_next;
            r_timer     <= w_timer_next;
            r_err       <= w_err_next;
        end
    end

    // Registered read-data path; RAM reads come straight from the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db <= 8'hFF;
        end else if (w_db_from_ram) begin
            r_db <= r_ram[w_ram_addr];
        end else begin
            r_db <= w_db_next;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= DO;
        end
    end

    assign DB        = r_db;
    assign RDY       = (r_state != S_REQ);
    assign ext_req   = r_ext_req;
    assign ext_we    = r_ext_we;
    assign ext_addr  = r_ext_addr;
    assign ext_wdata = r_ext_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scenario tasks plus randomized traffic checked against a
// behavioural model of the address map, RAM contents and I/O outcome rules.
module tb_bus_responder;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset_n;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DB;
    logic        RDY;
    logic        ext_req;
    logic        ext_we;
    logic [7:0]  ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] mem_model [0:4095];
    bit         mem_known [0:4095];
    logic [7:0] exp_db;
    bit         db_known;
    logic       exp_err;

    bus_responder #(.RAM_AW(12), .IO_PAGE(8'hD0), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .AB        (AB),
        .DO        (DO),
        .WE        (WE),
        .DB        (DB),
        .RDY       (RDY),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one access for one cycle (zero-wait-state path).
    task automatic drive(input logic [15:0] addr, input logic we, input logic [7:0] data);
        AB = addr;
        WE = we;
        DO = data;
        tick();
    endtask

    // Run one I/O access; ack on REQ cycle ack_cyc (outside 1..TIMEOUT = never).
    // Returns the stall length and the handshake outputs seen in the first REQ cycle.
    task automatic run_io(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                          input int ack_cyc, input logic [7:0] rdata, output int stall,
                          output logic [7:0] o_addr, output logic o_we,
                          output logic [7:0] o_wdata, output logic o_req);
        AB = addr;
        WE = we;
        DO = wdata;
        tick();
        stall   = 0;
        o_addr  = 8'hxx;
        o_we    = 1'bx;
        o_wdata = 8'hxx;
        o_req   = 1'bx;
        while (RDY === 1'b0 && stall < 40) begin
            stall++;
            if (stall == 1) begin
                o_addr  = ext_addr;
                o_we    = ext_we;
                o_wdata = ext_wdata;
                o_req   = ext_req;
            end
            ext_ack   = (stall == ack_cyc);
            ext_rdata = (stall == ack_cyc) ? rdata : 8'($urandom);
            tick();
            ext_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        AB        = 16'h8000;
        WE        = 1'b0;
        DO        = 8'h00;
        ext_ack   = 1'b0;
        ext_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b exp 1", RDY); end
        n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL reset_db got %h exp ff", DB); end
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", ext_req); end
        n_checks++; if (ext_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", ext_we); end
        n_checks++; if (ext_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", ext_addr); end
        n_checks++; if (ext_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h exp 00", ext_wdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        reset_n  = 1'b1;
        exp_db   = 8'hFF;
        db_known = 1'b1;
        exp_err  = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_ram();
        drive(16'h0123, 1'b1, 8'h5A);
        mem_model[12'h123] = 8'h5A;
        mem_known[12'h123] = 1'b1;
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL ram_wr_rdy got %b exp 1", RDY); end
        drive(16'h0123, 1'b0, 8'h00);
        exp_db = 8'h5A;
        n_checks++; if (DB !== 8'h5A) begin n_fail++; $display("FAIL ram_rd_db got %h exp 5a", DB); end
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL ram_rd_rdy got %b exp 1", RDY); end
        $display("txn ram write/read 0123 db=%h", DB);
    endtask

    task automatic test_unmapped();
        drive(16'h0000, 1'b1, 8'h3C);
        mem_model[0] = 8'h3C;
        mem_known[0] = 1'b1;
        drive(16'h0000, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'h3C) begin n_fail++; $display("FAIL unm_pre_db got %h exp 3c", DB); end
        drive(16'h8000, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL unm_rd_db got %h exp ff", DB); end
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL unm_rd_rdy got %b exp 1", RDY); end
        drive(16'h8000, 1'b1, 8'hA5);
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL unm_wr_req got %b exp 0", ext_req); end
        n_checks++; if (ext_addr !== 8'h00) begin n_fail++; $display("FAIL unm_wr_addr got %h exp 00", ext_addr); end
        n_checks++; if (ext_wdata !== 8'h00) begin n_fail++; $display("FAIL unm_wr_wdata got %h exp 00", ext_wdata); end
        drive(16'h0000, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'h3C) begin n_fail++; $display("FAIL unm_ram_intact got %h exp 3c", DB); end
        drive(16'h1000, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL unm_above_ram got %h exp ff", DB); end
        exp_db = 8'hFF;
        $display("txn unmapped read/write 8000 and 1000");
    endtask

    task automatic test_ack_ignored();
        AB        = 16'h0123;
        WE        = 1'b0;
        ext_ack   = 1'b1;
        ext_rdata = 8'h99;
        tick();
        ext_ack = 1'b0;
        exp_db  = 8'h5A;
        n_checks++; if (DB !== 8'h5A) begin n_fail++; $display("FAIL stray_ack_db got %h exp 5a", DB); end
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req got %b exp 0", ext_req); end
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL stray_ack_rdy got %b exp 1", RDY); end
        $display("txn stray ack in idle");
    endtask

    task automatic test_io_read();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        run_io(16'hD004, 1'b0, 8'h12, 3, 8'hC3, stall, oa, ow, od, oreq);
        exp_db = 8'hC3;
        n_checks++; if (oreq !== 1'b1) begin n_fail++; $display("FAIL ior_req got %b exp 1", oreq); end
        n_checks++; if (oa !== 8'h04) begin n_fail++; $display("FAIL ior_addr got %h exp 04", oa); end
        n_checks++; if (ow !== 1'b0) begin n_fail++; $display("FAIL ior_we got %b exp 0", ow); end
        n_checks++; if (stall != 3) begin n_fail++; $display("FAIL ior_stall got %0d exp 3", stall); end
        n_checks++; if (DB !== 8'hC3) begin n_fail++; $display("FAIL ior_db got %h exp c3", DB); end
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL ior_req_drop got %b exp 0", ext_req); end
        $display("txn io read d004 stall=%0d db=%h", stall, DB);
    endtask

    task automatic test_io_write();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        drive(16'h0010, 1'b1, 8'h11);
        mem_model[12'h010] = 8'h11;
        mem_known[12'h010] = 1'b1;
        drive(16'h0010, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'h11) begin n_fail++; $display("FAIL iow_pre_db got %h exp 11", DB); end
        run_io(16'hD010, 1'b1, 8'h77, 1, 8'hE8, stall, oa, ow, od, oreq);
        n_checks++; if (ow !== 1'b1) begin n_fail++; $display("FAIL iow_we got %b exp 1", ow); end
        n_checks++; if (od !== 8'h77) begin n_fail++; $display("FAIL iow_wdata got %h exp 77", od); end
        n_checks++; if (oa !== 8'h10) begin n_fail++; $display("FAIL iow_addr got %h exp 10", oa); end
        n_checks++; if (stall != 1) begin n_fail++; $display("FAIL iow_stall got %0d exp 1", stall); end
        n_checks++; if (DB !== 8'h11) begin n_fail++; $display("FAIL iow_db_hold got %h exp 11", DB); end
        drive(16'h0010, 1'b0, 8'h00);
        n_checks++; if (DB !== 8'h11) begin n_fail++; $display("FAIL iow_ram_intact got %h exp 11", DB); end
        exp_db = 8'h11;
        $display("txn io write d010 stall=%0d", stall);
    endtask

    task automatic test_ack_at_limit();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        run_io(16'hD030, 1'b0, 8'h00, TIMEOUT, 8'h6B, stall, oa, ow, od, oreq);
        exp_db = 8'h6B;
        n_checks++; if (stall != TIMEOUT) begin n_fail++; $display("FAIL lim_stall got %0d exp %0d", stall, TIMEOUT); end
        n_checks++; if (DB !== 8'h6B) begin n_fail++; $display("FAIL lim_db got %h exp 6b", DB); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL lim_err got %b exp 0", err); end
        $display("txn io read d030 ack at last cycle stall=%0d", stall);
    endtask

    task automatic test_timeout();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        run_io(16'hD020, 1'b0, 8'h00, 0, 8'h00, stall, oa, ow, od, oreq);
        exp_db  = 8'hFF;
        exp_err = 1'b1;
        n_checks++; if (stall != TIMEOUT) begin n_fail++; $display("FAIL to_stall got %0d exp %0d", stall, TIMEOUT); end
        n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL to_db got %h exp ff", DB); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", err); end
        run_io(16'hD021, 1'b0, 8'h00, 2, 8'h42, stall, oa, ow, od, oreq);
        exp_db = 8'h42;
        n_checks++; if (DB !== 8'h42) begin n_fail++; $display("FAIL to_next_db got %h exp 42", DB); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b exp 1", err); end
        drive(16'h0123, 1'b0, 8'h00);
        exp_db = 8'h5A;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky2 got %b exp 1", err); end
        $display("txn io timeout d020 stall=%0d err=%b", stall, err);
    endtask

    task automatic test_back_to_back();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        run_io(16'hD001, 1'b0, 8'h00, 1, 8'hA1, stall, oa, ow, od, oreq);
        n_checks++; if (DB !== 8'hA1) begin n_fail++; $display("FAIL b2b_db1 got %h exp a1", DB); end
        run_io(16'hD002, 1'b0, 8'h00, 2, 8'hB2, stall, oa, ow, od, oreq);
        exp_db = 8'hB2;
        n_checks++; if (oreq !== 1'b1) begin n_fail++; $display("FAIL b2b_req got %b exp 1", oreq); end
        n_checks++; if (oa !== 8'h02) begin n_fail++; $display("FAIL b2b_addr got %h exp 02", oa); end
        n_checks++; if (stall != 2) begin n_fail++; $display("FAIL b2b_stall got %0d exp 2", stall); end
        n_checks++; if (DB !== 8'hB2) begin n_fail++; $display("FAIL b2b_db2 got %h exp b2", DB); end
        $display("txn back-to-back io d001/d002");
    endtask

    task automatic test_random();
        int stall; logic [7:0] oa; logic ow; logic [7:0] od; logic oreq;
        for (int t = 0; t < 60; t++) begin
            int          kind;
            logic [15:0] addr;
            logic        we;
            logic [7:0]  data;
            kind = $urandom_range(0, 9);
            we   = 1'($urandom);
            data = 8'($urandom);
            if (kind <= 4) begin
                addr = 16'h0100 + 16'($urandom_range(0, 15));
                drive(addr, we, data);
                n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL rnd_ram_rdy got %b exp 1", RDY); end
                if (we) begin
                    mem_model[addr[11:0]] = data;
                    mem_known[addr[11:0]] = 1'b1;
                end else if (mem_known[addr[11:0]]) begin
                    exp_db = mem_model[addr[11:0]];
                    db_known = 1'b1;
                    n_checks++; if (DB !== exp_db) begin n_fail++; $display("FAIL rnd_ram_db addr %h got %h exp %h", addr, DB, exp_db); end
                end else begin
                    db_known = 1'b0;
                end
                $display("txn %0d ram %s addr=%h data=%h db=%h", t, we ? "wr" : "rd", addr, data, DB);
            end else if (kind <= 6) begin
                addr = 16'($urandom_range(16'h1000, 16'hFFFF));
                if (addr[15:8] == 8'hD0) addr = 16'hE000 | {8'h00, addr[7:0]};
                drive(addr, we, data);
                n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rnd_unm_req got %b exp 0", ext_req); end
                if (!we) begin
                    exp_db = 8'hFF;
                    db_known = 1'b1;
                    n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL rnd_unm_db addr %h got %h exp ff", addr, DB); end
                end
                $display("txn %0d unmapped %s addr=%h", t, we ? "wr" : "rd", addr);
            end else begin
                int         ack_cyc;
                int         exp_stall;
                bit         acked;
                logic [7:0] rdata;
                addr    = 16'hD000 | 16'($urandom_range(0, 255));
                ack_cyc = $urandom_range(1, TIMEOUT + 2);
                rdata   = 8'($urandom);
                acked   = (ack_cyc <= TIMEOUT);
                exp_stall = acked ? ack_cyc : TIMEOUT;
                run_io(addr, we, data, ack_cyc, rdata, stall, oa, ow, od, oreq);
                if (!we) begin
                    exp_db = acked ? rdata : 8'hFF;
                    db_known = 1'b1;
                end
                if (!acked) exp_err = 1'b1;
                n_checks++; if (oa !== addr[7:0]) begin n_fail++; $display("FAIL rnd_io_addr got %h exp %h", oa, addr[7:0]); end
                n_checks++; if (ow !== we) begin n_fail++; $display("FAIL rnd_io_we got %b exp %b", ow, we); end
                n_checks++; if (od !== data) begin n_fail++; $display("FAIL rnd_io_wdata got %h exp %h", od, data); end
                n_checks++; if (stall != exp_stall) begin n_fail++; $display("FAIL rnd_io_stall got %0d exp %0d", stall, exp_stall); end
                n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_io_err got %b exp %b", err, exp_err); end
                n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rnd_io_req_drop got %b exp 0", ext_req); end
                if (db_known) begin
                    n_checks++; if (DB !== exp_db) begin n_fail++; $display("FAIL rnd_io_db got %h exp %h", DB, exp_db); end
                end
                $display("txn %0d io %s addr=%h ack_cyc=%0d stall=%0d db=%h err=%b", t, we ? "wr" : "rd", addr, ack_cyc, stall, DB, err);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        AB = 16'hD040;
        WE = 1'b0;
        tick();
        n_checks++; if (RDY !== 1'b0) begin n_fail++; $display("FAIL rst_pre_rdy got %b exp 0", RDY); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req got %b exp 0", ext_req); end
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_async_rdy got %b exp 1", RDY); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_async_err got %b exp 0", err); end
        AB = 16'h8000;
        #1 reset_n = 1'b1;
        ext_ack   = 1'b1;
        ext_rdata = 8'h5E;
        tick();
        ext_ack = 1'b0;
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_late_ack_rdy got %b exp 1", RDY); end
        n_checks++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack_req got %b exp 0", ext_req); end
        n_checks++; if (DB !== 8'hFF) begin n_fail++; $display("FAIL rst_late_ack_db got %h exp ff", DB); end
        tick();
        n_checks++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_idle_rdy got %b exp 1", RDY); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_idle_err got %b exp 0", err); end
        $display("txn reset during io request");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_known[i] = 1'b0;
            mem_model[i] = 8'h00;
        end
        test_reset();
        test_ram();
        test_unmapped();
        test_ack_ignored();
        test_io_read();
        test_io_write();
        test_ack_at_limit();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
